// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M funct3 opcodes, FSM states, default width.
package mdu_pkg;

   localparam int MDU_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step_i, DATA_WIDTH steps per divide.
// No handshake of its own; the parent loads it and holds step_i low to freeze the result.
module mdu_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o
);

   logic [DATA_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH+1:0] diff;

   assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (load_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (step_i) begin
         // Borrow out of the trial subtraction means the divisor did not fit.
         if (!diff[DATA_WIDTH+1]) begin
            rem_d = diff[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: DATA_WIDTH+1 cycles per op, 1 cycle for trivial cases; result held until rsp_ready.
// Divide/remainder hardware exists only with MDU_ITER_DIV_EN defined; otherwise those ops return 0 in 1 cycle.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] MDUResult,
   output logic                  busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   mdu_state_e            state_q, state_d;
   mdu_op_e               op_in, op_q, op_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  neg_q, neg_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;

   logic                    a_signed, b_signed, a_neg, b_neg, is_div, hs, quick, step;
   logic [DATA_WIDTH-1:0]   mag_a, mag_b, quick_res, mul_res, final_res;
   logic [DATA_WIDTH:0]     sum;
   logic [2*DATA_WIDTH-1:0] prod, prod_s;

   assign op_in    = mdu_op_e'(Operation);
   assign is_div   = Operation[2];
   assign a_signed = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) || (op_in == MDU_DIV) || (op_in == MDU_REM);
   assign b_signed = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
   assign a_neg    = a_signed && SrcA[DATA_WIDTH-1];
   assign b_neg    = b_signed && SrcB[DATA_WIDTH-1];
   assign mag_a    = a_neg ? (~SrcA + 1'b1) : SrcA;
   assign mag_b    = b_neg ? (~SrcB + 1'b1) : SrcB;

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign hs        = req_valid && req_ready && !flush;
   assign step      = (state_q == ST_CALC);

   // Shift-add on magnitudes: {hi,lo} starts as {0, |b|} and ends as |a|*|b|.
   assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign prod    = {hi_q, lo_q};
   assign prod_s  = neg_q ? (~prod + 1'b1) : prod;
   assign mul_res = (op_q == MDU_MUL) ? prod_s[DATA_WIDTH-1:0] : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef MDU_ITER_DIV_EN
   logic                  div_zero, div_ovf, op_q_div;
   logic [DATA_WIDTH-1:0] quo, rem, div_raw, div_res;

   assign div_zero  = is_div && (SrcB == '0);
   assign div_ovf   = is_div && !Operation[0] && (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (SrcB == '1);
   assign quick     = div_zero || div_ovf;
   assign quick_res = Operation[1] ? (div_zero ? SrcA : '0) : (div_zero ? '1 : SrcA);
   assign op_q_div  = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   assign div_raw   = (op_q == MDU_REM || op_q == MDU_REMU) ? rem : quo;
   assign div_res   = neg_q ? (~div_raw + 1'b1) : div_raw;
   assign final_res = op_q_div ? div_res : mul_res;

   mdu_divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (hs && is_div && !quick),
      .step_i      (step && op_q_div),
      .dividend_i  (mag_a),
      .divisor_i   (mag_b),
      .quotient_o  (quo),
      .remainder_o (rem)
   );
`else
   assign quick     = is_div;
   assign quick_res = '0;
   assign final_res = mul_res;
`endif

   // Shortcut results are parked in lo with op forced to MUL so the output mux passes them through.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hs) begin
               cnt_d = '0;
               hi_d  = '0;
               if (quick) begin
                  state_d = ST_DONE;
                  op_d    = MDU_MUL;
                  neg_d   = 1'b0;
                  lo_d    = quick_res;
               end else begin
                  state_d = ST_CALC;
                  op_d    = op_in;
                  neg_d   = (op_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);
                  lo_d    = mag_b;
                  mcand_d = mag_a;
               end
            end
         end
         ST_CALC: begin
            hi_d  = sum[DATA_WIDTH:1];
            lo_d  = {sum[0], lo_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MDU_MUL;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
      end
   end

   assign MDUResult = (state_q == ST_DONE) ? final_res : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes model results, monitor pops and compares on each response.
module tb_mdu_iter;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          issued;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  Operation = 3'b000;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] MDUResult;
   logic        busy;

   int   vecs = 0;
   int   miscmp = 0;
   int   cyc = 0;
   logic hold_low = 1'b0;
   logic force_hi = 1'b0;
   exp_t exp_q[$];

   mdu_iter #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .MDUResult (MDUResult),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vecs++;
      if (act !== req) begin
         miscmp++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: full-width arithmetic straight from the RV32M definitions.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int issued);
      exp_t        e;
      logic [63:0] ea, eb, p;
      int          sa, sb;
      e.issued = issued;
      e.lat    = 33;
      e.res    = '0;
      sa = a;
      sb = b;
      if (op < 3'd4) begin
         ea = (op == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
         eb = (op == 3'd0 || op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
         p  = ea * eb;
         e.res = (op == 3'd0) ? p[31:0] : p[63:32];
      end else begin
`ifdef MDU_ITER_DIV_EN
         if (b == 0) begin
            e.lat = 1;
            e.res = op[1] ? a : 32'hFFFF_FFFF;
         end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lat = 1;
            e.res = op[1] ? 32'd0 : a;
         end else begin
            case (op)
               3'd4:    e.res = sa / sb;
               3'd5:    e.res = a / b;
               3'd6:    e.res = sa % sb;
               default: e.res = a % b;
            endcase
         end
`else
         e.lat = 1;
         e.res = '0;
`endif
      end
      return e;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
      req_valid = 1'b1;
      Operation = op;
      SrcA = a;
      SrcB = b;
      exp_q.push_back(model(op, a, b, cyc));
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1 rsp_ready = hold_low ? 1'b0 : force_hi ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      logic seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
               e = exp_q[0];
               if (!seen) begin
                  chk("latency", 32'(cyc - e.issued), 32'(e.lat));
                  seen = 1'b1;
               end
               chk("result", MDUResult, e.res);
               chk("req_ready_in_done", req_ready, 1'b0);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin : stim
      logic [2:0]  dir_op[9] = '{3'd3, 3'd4, 3'd6, 3'd5, 3'd5, 3'd4, 3'd6, 3'd4, 3'd2};
      logic [31:0] dir_a[9]  = '{32'hFFFF_FFFF, -32'sd7, -32'sd7, 32'd100, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'd10, 32'h8000_0000};
      logic [31:0] dir_b[9]  = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
      int guard;

      repeat (3) @(negedge clk);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_result", MDUResult, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1'b1);

      // Held-off consumer: result must stay put and no new request accepted.
      hold_low = 1'b1;
      issue(3'd0, 32'd7, -32'sd3);
      guard = 0;
      while (!rsp_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("hold_rsp_seen", rsp_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1'b1);
      end
      hold_low = 1'b0;
      force_hi = 1'b1;
      guard = 0;
      while (!(rsp_valid && rsp_ready) && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      chk("idle_after_accept", {req_ready, rsp_valid}, 2'b10);
      force_hi = 1'b0;

      for (int i = 0; i < 9; i++) issue(dir_op[i], dir_a[i], dir_b[i]);

      // Flush in the twelfth CALC cycle.
      issue(3'd0, 32'd5, 32'd6);
      repeat (12) @(negedge clk);
      void'(exp_q.pop_back());
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_idle", {busy, rsp_valid, req_ready}, 3'b001);
      issue(3'd0, 32'd3, 32'd4);

      // Reset in the fifth CALC cycle.
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (5) @(negedge clk);
      void'(exp_q.pop_back());
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_outputs", {rsp_valid, busy}, 2'b00);
      chk("midreset_result", MDUResult, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_ready", req_ready, 1'b1);
      repeat (40) @(negedge clk);

      for (int i = 0; i < 120; i++) issue(3'($urandom_range(0, 7)), pick(), pick());

      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; iteration count equals DATA_WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1  abort the in-flight operation (pipeline redirect).
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port Operation  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port SrcA  input  DATA_WIDTH  rs1 operand.
REQ-009 SHALL have port SrcB  input  DATA_WIDTH  rs2 operand.
REQ-010 SHALL have port rsp_valid  output  1  result valid.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port MDUResult  output  DATA_WIDTH  result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE (pipeline stall source).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid && req_ready, and operands and Operation are captured on that edge.
REQ-016 SHALL go from IDLE to CALC on handshake, except the special cases in REQ-020/REQ-021, which go directly to DONE.
REQ-017 SHALL perform one radix-2 step per CALC cycle (shift-add multiply, restoring divide on magnitudes), then move to DONE after exactly DATA_WIDTH steps; handshake-to-rsp_valid latency is DATA_WIDTH+1 cycles.
REQ-018 SHALL return: MUL = low word; MULH/MULHSU/MULHU = high word of the 2*DATA_WIDTH product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-019 SHALL round signed DIV toward zero; remainder sign follows dividend; DIVU/REMU are unsigned.
REQ-020 SHALL, on divide-by-zero, return DIV/DIVU = all ones and REM/REMU = SrcA, with latency 1 cycle.
REQ-021 SHALL, on signed overflow (SrcA = most-negative, SrcB = -1), return DIV = SrcA and REM = 0, with latency 1 cycle.
REQ-022 SHALL hold rsp_valid and a stable MDUResult in DONE until rsp_ready, then return to IDLE; the next request cannot be accepted in the same cycle as rsp_ready.
REQ-023 SHALL, when flush is high in any state, go to IDLE on the next edge with rsp_valid low and discard the result; flush has priority over handshake and over rsp_ready.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, force state IDLE, rsp_valid 0, busy 0, MDUResult 0, and iteration counter 0; req_ready SHALL be 1 in the first cycle after reset release.
REQ-025 SHALL abandon any operation in progress when reset is asserted; no response SHALL appear afterwards.

Configuration
REQ-026 SHALL compile in divide/remainder support only when macro MDU_ITER_DIV_EN is defined.
REQ-027 SHALL, without MDU_ITER_DIV_EN, accept funct3 100-111 and complete each in 1 cycle with MDUResult = 0; multiply behaviour SHALL be unchanged.

Structure
REQ-028 SHALL take from shared package mdu_pkg: the funct3 op enum mdu_op_e, the FSM state enum mdu_state_e, and localparam MDU_DATA_WIDTH = 32.
REQ-029 SHALL place the iterative restoring divider in sub-module mdu_divider, instantiated only under MDU_ITER_DIV_EN; the multiplier datapath stays in mdu_iter.

Verification
REQ-030 SHALL cover: MUL 7 * -3 -> rsp_valid at cycle 33, MDUResult 0xFFFFFFEB; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-032 SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000 / -1 -> 0x80000000 after 1 cycle; REM of the same operands -> 0.
REQ-033 SHALL cover: rsp_ready held low 10 cycles in DONE -> MDUResult stable and req_ready low throughout; rsp_ready high -> IDLE on the next cycle.
REQ-034 SHALL cover: flush at CALC cycle 12 -> IDLE next cycle, no rsp_valid; then a new MUL 3 * 4 -> 12.
REQ-035 SHALL cover: rst_n low at CALC cycle 5 -> all outputs at reset values, no response; and with MDU_ITER_DIV_EN undefined, DIV 10 / 2 -> 0 after 1 cycle.
